// File: rtl/emulib_scan_dma_ctrl_if.sv
// emulib_scan_dma_ctrl_if: CSR, scan-chain and DMA stream signals of the scan checkpoint controller
interface emulib_scan_dma_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  ctrl_wen;
  logic [5:0]            ctrl_waddr;
  logic [31:0]           ctrl_wdata;
  logic                  ctrl_ren;
  logic [5:0]            ctrl_raddr;
  logic [31:0]           ctrl_rdata;
  logic                  ff_se;
  logic [DATA_WIDTH-1:0] ff_di;
  logic [DATA_WIDTH-1:0] ff_do;
  logic                  ram_sr;
  logic                  ram_se;
  logic                  ram_sd;
  logic [DATA_WIDTH-1:0] ram_di;
  logic [DATA_WIDTH-1:0] ram_do;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [CNT_WIDTH-1:0]  cmd_count;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  dma_idle;
  logic                  dma_err;
  modport master (
    input  ctrl_wen, ctrl_waddr, ctrl_wdata, ctrl_ren, ctrl_raddr, ff_do, ram_do,
           cmd_ready, rd_valid, rd_data, wr_ready, dma_idle, dma_err,
    output ctrl_rdata, ff_se, ff_di, ram_sr, ram_se, ram_sd, ram_di,
           cmd_valid, cmd_dir, cmd_addr, cmd_count, rd_ready, wr_valid, wr_data
  );
  modport slave (
    output ctrl_wen, ctrl_waddr, ctrl_wdata, ctrl_ren, ctrl_raddr, ff_do, ram_do,
           cmd_ready, rd_valid, rd_data, wr_ready, dma_idle, dma_err,
    input  ctrl_rdata, ff_se, ff_di, ram_sr, ram_se, ram_sd, ram_di,
           cmd_valid, cmd_dir, cmd_addr, cmd_count, rd_ready, wr_valid, wr_data
  );
endinterface

// File: rtl/emulib_scan_dma_ctrl.sv
// emulib_scan_dma_ctrl: moves FF and RAM scan-chain contents to/from host memory over a stream DMA
module emulib_scan_dma_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int FF_COUNT   = 0,
  parameter int MEM_COUNT  = 0,
  parameter int CNT_WIDTH  = 32
) (
  input logic host_clk,
  input logic host_rst_n,
  emulib_scan_dma_ctrl_if.master bus
);
  localparam logic [3:0] S_IDLE = 4'd0, S_CMD = 4'd1, S_FF_RST = 4'd2, S_FF_SCAN = 4'd3,
    S_RAM_RST = 4'd4, S_RAM_PREP1 = 4'd5, S_RAM_PREP2 = 4'd6, S_RAM_SCAN = 4'd7,
    S_DRAIN = 4'd8, S_DONE = 4'd9;
  localparam logic [CNT_WIDTH-1:0] TOTAL = CNT_WIDTH'(FF_COUNT + MEM_COUNT);
  localparam logic [CNT_WIDTH-1:0] FF_LAST = CNT_WIDTH'(FF_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] MEM_LAST = CNT_WIDTH'(MEM_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic [3:0] state_q, state_d;
  logic dir_q, dir_d, done_q, done_d, abrt_q, abrt_d, err_q, err_d, abort_q, abort_d;
  logic [31:0] base_lo_q, base_lo_d, base_hi_q, base_hi_d;
  logic [CNT_WIDTH-1:0] prog_q, prog_d, ff_cnt_q, ff_cnt_d, ram_cnt_q, ram_cnt_d;
  logic busy, wr_ctrl, wr_stat, start, abort_req, ab, scan, beat, fin;
  assign busy = state_q != S_IDLE;
  assign wr_ctrl = bus.ctrl_wen && bus.ctrl_waddr == 6'h00;
  assign wr_stat = bus.ctrl_wen && bus.ctrl_waddr == 6'h04;
  assign start = wr_ctrl && !busy && bus.ctrl_wdata[0];
  assign abort_req = wr_ctrl && busy && bus.ctrl_wdata[2];
  assign ab = abort_q || abort_req;
  assign scan = state_q == S_FF_SCAN || state_q == S_RAM_SCAN;
  assign beat = scan && (dir_q ? bus.rd_valid : bus.wr_ready);
  assign fin = state_q == S_DRAIN && bus.dma_idle;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = !start ? S_IDLE : (TOTAL == '0) ? S_DONE : S_CMD;
      S_CMD:       state_d = !bus.cmd_ready ? S_CMD : ab ? S_DRAIN : S_FF_RST;
      S_FF_RST:    state_d = ab ? S_DRAIN : (FF_COUNT == 0) ? S_RAM_RST : S_FF_SCAN;
      S_FF_SCAN:   state_d = ab ? S_DRAIN : (beat && ff_cnt_q == FF_LAST) ? S_RAM_RST : S_FF_SCAN;
      S_RAM_RST:   state_d = (ab || MEM_COUNT == 0) ? S_DRAIN : dir_q ? S_RAM_SCAN : S_RAM_PREP1;
      S_RAM_PREP1: state_d = ab ? S_DRAIN : S_RAM_PREP2;
      S_RAM_PREP2: state_d = ab ? S_DRAIN : S_RAM_SCAN;
      S_RAM_SCAN:  state_d = (ab || (beat && ram_cnt_q == MEM_LAST)) ? S_DRAIN : S_RAM_SCAN;
      S_DRAIN:     state_d = !bus.dma_idle ? S_DRAIN : ab ? S_IDLE : S_DONE;
      default:     state_d = S_IDLE;
    endcase
  end
  // Status bits: START clears, hardware events set, W1C writes clear
  always_comb begin
    dir_d = (wr_ctrl && !busy) ? bus.ctrl_wdata[1] : dir_q;
    base_lo_d = (bus.ctrl_wen && !busy && bus.ctrl_waddr == 6'h08) ? bus.ctrl_wdata : base_lo_q;
    base_hi_d = (ADDR_WIDTH > 32 && bus.ctrl_wen && !busy && bus.ctrl_waddr == 6'h0C) ? bus.ctrl_wdata : base_hi_q;
    abort_d = (state_d == S_IDLE || state_d == S_DONE) ? 1'b0 : ab;
    done_d = !start && (state_q == S_DONE || (done_q && !(wr_stat && bus.ctrl_wdata[0])));
    abrt_d = !start && ((fin && ab) || (abrt_q && !(wr_stat && bus.ctrl_wdata[2])));
    err_d = !start && ((busy && bus.dma_err) || (err_q && !(wr_stat && bus.ctrl_wdata[3])));
    prog_d = start ? '0 : (beat && prog_q != '1) ? prog_q + ONE : prog_q;
    ff_cnt_d = (state_q == S_FF_RST) ? '0 : (state_q == S_FF_SCAN && beat) ? ff_cnt_q + ONE : ff_cnt_q;
    ram_cnt_d = (state_q == S_RAM_RST) ? '0 : (state_q == S_RAM_SCAN && beat) ? ram_cnt_q + ONE : ram_cnt_q;
  end
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state_q <= S_IDLE;
      dir_q <= 1'b0;
      done_q <= 1'b0;
      abrt_q <= 1'b0;
      err_q <= 1'b0;
      abort_q <= 1'b0;
      base_lo_q <= '0;
      base_hi_q <= '0;
      prog_q <= '0;
      ff_cnt_q <= '0;
      ram_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      done_q <= done_d;
      abrt_q <= abrt_d;
      err_q <= err_d;
      abort_q <= abort_d;
      base_lo_q <= base_lo_d;
      base_hi_q <= base_hi_d;
      prog_q <= prog_d;
      ff_cnt_q <= ff_cnt_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end
  // Data outputs are gated to zero outside their active states so reset drives every output low
  assign bus.cmd_valid = state_q == S_CMD;
  assign bus.cmd_dir = bus.cmd_valid && dir_q;
  assign bus.cmd_addr = bus.cmd_valid ? ADDR_WIDTH'({base_hi_q, base_lo_q}) : '0;
  assign bus.cmd_count = bus.cmd_valid ? TOTAL : '0;
  assign bus.ff_se = state_q == S_FF_SCAN && beat;
  assign bus.ff_di = (state_q != S_FF_SCAN) ? '0 : dir_q ? bus.rd_data : bus.ff_do;
  assign bus.ram_sr = state_q == S_RAM_RST;
  assign bus.ram_se = state_q == S_RAM_PREP1 || state_q == S_RAM_PREP2 || (state_q == S_RAM_SCAN && beat);
  assign bus.ram_sd = state_q == S_RAM_SCAN && dir_q;
  assign bus.ram_di = bus.ram_sd ? bus.rd_data : '0;
  assign bus.rd_ready = (scan && dir_q) || (state_q == S_DRAIN && abort_q);
  assign bus.wr_valid = scan && !dir_q;
  assign bus.wr_data = !bus.wr_valid ? '0 : (state_q == S_FF_SCAN) ? bus.ff_do : bus.ram_do;
  assign bus.ctrl_rdata = !bus.ctrl_ren ? 32'h0 :
    (bus.ctrl_raddr == 6'h00) ? {30'h0, dir_q, busy} :
    (bus.ctrl_raddr == 6'h04) ? {28'h0, err_q, abrt_q, 1'b0, done_q} :
    (bus.ctrl_raddr == 6'h08) ? base_lo_q :
    (bus.ctrl_raddr == 6'h0C) ? ((ADDR_WIDTH > 32) ? base_hi_q : 32'h0) :
    (bus.ctrl_raddr == 6'h10) ? 32'(prog_q) :
    (bus.ctrl_raddr == 6'h14) ? {16'(MEM_COUNT), 16'(FF_COUNT)} : 32'h0;
endmodule
